streaming_saturating_integrator: RTL
====================================

// Module: streaming_saturating_integrator
// PURPOSE
//  Next-generation neuron integrator for the core's neuron block. Accepts one neuron's start
//  potential, then a valid/ready stream of signed synaptic weights, accumulates them, applies one leak
//  term, and presents the final potential on a valid/ready output. Adds handshaking, per-neuron
//  beat counting, optional saturation and a length-error flag. Sits between the synapse-weight
//  fetch and the threshold/reset unit.
// PARAMETERS
//  WEIGHT_WIDTH    9    signed weight width; must be <= POTENTIAL_WIDTH
//  POTENTIAL_WIDTH 9    signed membrane potential width
//  LEAK_WIDTH      9    signed leak width; must be <= POTENTIAL_WIDTH
//  NUM_AXONS       256  max weight beats per neuron
//  SATURATE        1    1: clamp to signed range; 0: two's-complement wrap
//  CW = $clog2(NUM_AXONS+1) (localparam)
// PORTS
//  clk             in   1    clock
//  reset           in   1    synchronous, active-high
//  start_valid     in   1    new neuron offered
//  start_ready     out  1    integrator idle, can accept neuron
//  start_potential in   P    initial potential (signed)
//  start_leak      in   L    leak for this neuron (signed)
//  start_empty     in   1    neuron has no weight beats; skip to leak
//  wt_valid        in   1    weight beat valid
//  wt_ready        out  1    weight beat accepted when valid&&ready
//  wt_data         in   W    signed weight
//  wt_last         in   1    final beat of this neuron
//  out_valid       out  1    result valid, held until out_ready
//  out_ready       in   1    downstream accepts result
//  out_potential   out  P    final potential
//  out_count       out  CW   weight beats accepted for this neuron
//  out_sat         out  1    saturation occurred in any add (0 if SATURATE=0)
//  out_len_err     out  1    NUM_AXONS beats reached without wt_last
// BEHAVIOUR
//  Reset: state=IDLE; start_ready=1, wt_ready=0, out_valid=0; out_potential, out_count, out_sat,
//   out_len_err = 0. Reset in any state discards the in-flight neuron; no partial output.
//  States IDLE -> INTEGRATE -> LEAK -> DONE -> IDLE. All outputs are registered or pure
//   state decodes; no combinational in->out path.
//  IDLE: start_ready=1. On start_valid: acc<=start_potential, leak<=start_leak, count<=0,
//   sat<=0, err<=0; go to LEAK if start_empty, else INTEGRATE.
//  INTEGRATE: wt_ready=1. Each accepted beat: acc<=f(acc+sext(wt_data)), count<=count+1.
//   Accepted with wt_last -> LEAK. Accepted without wt_last with count+1==NUM_AXONS -> LEAK,
//   err<=1; wt_ready drops so further beats stall. wt_valid low: hold, no change.
//  LEAK: one cycle; acc<=f(acc+sext(leak)) -> DONE.
//  DONE: out_valid=1, outputs stable; on out_ready -> IDLE. A new start is accepted
//   no earlier than the cycle after the handshake (one bubble per neuron).
//  Latency: last-beat acceptance at cycle t -> LEAK at t+1 -> out_valid high at t+2.
//  Arithmetic f: sum computed at POTENTIAL_WIDTH+1 bits from sign-extended operands.
//   SATURATE=1: clamp to [-2^(P-1), 2^(P-1)-1]; set sat on clamp; sat is sticky per neuron.
//   SATURATE=0: keep low P bits (wrap); sat stays 0.
//  Leak also saturates and sets sat. Weight 0 beats count normally.
// STRUCTURE
//  Shared package integrator_pkg: state enum (IDLE, INTEGRATE, LEAK, DONE) and
//   sat-range constants as functions of POTENTIAL_WIDTH.
//  One sub-module: sat_adder (sign-extend a, b; P+1-bit add; clamp/wrap by SATURATE;
//   sat flag out). Instanced once and muxed between weight and leak.
// TESTING (P=W=L=9, SATURATE=1 unless noted)
//  start 10, leak -1; wts 5,-3,7(last) -> out 18, count 3, sat 0, err 0; valid at last+2.
//  start 250, wt 100(last), leak 0 -> 255, sat 1. start -250, wt -20(last), leak -5 -> -256, sat 1.
//  SATURATE=0: start 250, wt 10(last), leak 0 -> -252, sat 0.
//  NUM_AXONS=4: start 0, four wts of 1 without last -> out 4, count 4, err 1; 5th beat stalls (wt_ready 0).
//  start_empty=1, start 7, leak 3 -> out 10, count 0, valid 2 cycles after start handshake.
//  out_ready low 5 cycles -> outputs stable, start_ready 0; reset mid-INTEGRATE -> next cycle
//   out_valid 0, start_ready 1, next neuron result unaffected by discarded beats.

Source files
------------

// File: rtl/integrator_pkg.sv
// integrator_pkg: shared FSM state type and signed saturation bounds for the neuron integrator
package integrator_pkg;
  typedef enum logic [1:0] {IDLE, INTEGRATE, LEAK, DONE} state_t;
  function automatic int sat_max(input int p);
    return (1 << (p - 1)) - 1;
  endfunction
  function automatic int sat_min(input int p);
    return -(1 << (p - 1));
  endfunction
endpackage

// File: rtl/sat_adder.sv
// sat_adder: P-bit signed add computed at P+1 bits, clamped (SATURATE=1) or wrapped (SATURATE=0)
// Ports: a, b signed addends; sum result; sat high when the result was clamped.
module sat_adder
  import integrator_pkg::*;
#(
  parameter int P        = 9,
  parameter int SATURATE = 1
) (
  input  logic [P-1:0] a,
  input  logic [P-1:0] b,
  output logic [P-1:0] sum,
  output logic         sat
);
  localparam logic [P-1:0] MAXV = P'(sat_max(P));
  localparam logic [P-1:0] MINV = P'(sat_min(P));
  logic [P:0] wide;
  logic       ovf;
  always_comb begin
    wide = {a[P-1], a} + {b[P-1], b};
    ovf  = wide[P] ^ wide[P-1];
    sat  = (SATURATE != 0) && ovf;
    sum  = sat ? (wide[P] ? MINV : MAXV) : wide[P-1:0];
  end
endmodule

// File: rtl/streaming_saturating_integrator.sv
// streaming_saturating_integrator: accumulates a stream of signed weights plus one leak onto a start potential
// Ports: start_* neuron handshake (potential, leak, empty); wt_* weight stream with last;
//        out_* result handshake with potential, beat count, sticky saturation and length-error flags.
module streaming_saturating_integrator
  import integrator_pkg::*;
#(
  parameter int  WEIGHT_WIDTH    = 9,
  parameter int  POTENTIAL_WIDTH = 9,
  parameter int  LEAK_WIDTH      = 9,
  parameter int  NUM_AXONS       = 256,
  parameter int  SATURATE        = 1,
  localparam int CW              = $clog2(NUM_AXONS + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [POTENTIAL_WIDTH-1:0] start_potential,
  input  logic [LEAK_WIDTH-1:0]      start_leak,
  input  logic                       start_empty,
  input  logic                       wt_valid,
  output logic                       wt_ready,
  input  logic [WEIGHT_WIDTH-1:0]    wt_data,
  input  logic                       wt_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [POTENTIAL_WIDTH-1:0] out_potential,
  output logic [CW-1:0]              out_count,
  output logic                       out_sat,
  output logic                       out_len_err
);
  localparam int P = POTENTIAL_WIDTH;
  state_t         state, next;
  logic [P-1:0]   acc, leak, sum, addend;
  logic [CW-1:0]  count;
  logic           sat, err, add_sat, start_fire, beat, at_max;
  always_comb begin
    start_fire = state == IDLE && start_valid;
    beat       = state == INTEGRATE && wt_valid;
    at_max     = count == CW'(NUM_AXONS - 1);
    addend     = state == LEAK ? leak : P'($signed(wt_data));
    next       = state;
    if (start_fire) next = start_empty ? LEAK : INTEGRATE;
    if (beat && (wt_last || at_max)) next = LEAK;
    if (state == LEAK) next = DONE;
    if (state == DONE && out_ready) next = IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  sat_adder #(.P(P), .SATURATE(SATURATE)) u_add (
    .a  (acc),
    .b  (addend),
    .sum(sum),
    .sat(add_sat)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      leak  <= '0;
      count <= '0;
      sat   <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (start_fire) begin
        acc   <= start_potential;
        leak  <= P'($signed(start_leak));
        count <= '0;
        sat   <= 1'b0;
        err   <= 1'b0;
      end
      if (beat || state == LEAK) begin
        acc <= sum;
        sat <= sat | add_sat;
      end
      if (beat) begin
        count <= count + 1'b1;
        err   <= err | (!wt_last && at_max);
      end
    end
  end
  assign start_ready   = state == IDLE;
  assign wt_ready      = state == INTEGRATE;
  assign out_valid     = state == DONE;
  assign out_potential = acc;
  assign out_count     = count;
  assign out_sat       = sat;
  assign out_len_err   = err;
endmodule
